// File: rtl/tile_judge_pkg.sv
// Shared definitions for the piano-tiles datapath: lane count, lane keycodes,
// game state encoding and the packed lane-Y helpers used by the judge and the movers.
package tile_pkg;

   localparam int unsigned LANES = 4;

   // USB HID usage codes for the four lane keys
   localparam logic [7:0] KEY_A = 8'h04;
   localparam logic [7:0] KEY_S = 8'h16;
   localparam logic [7:0] KEY_D = 8'h07;
   localparam logic [7:0] KEY_F = 8'h09;

   typedef enum logic {
      PLAY = 1'b0,
      OVER = 1'b1
   } game_state_t;

   // Keycode for a lane; lanes without a key return 0 (never a valid press)
   function automatic logic [7:0] lane_key(input int unsigned lane);
      logic [7:0] code;
      unique case (lane)
         0:       code = KEY_A;
         1:       code = KEY_S;
         2:       code = KEY_D;
         3:       code = KEY_F;
         default: code = 8'h00;
      endcase
      return code;
   endfunction

   // Lane i occupies bits [10i+9:10i] of the packed Y bus
   function automatic logic [9:0] lane_y(input logic [LANES*10-1:0] ys, input int unsigned lane);
      return ys[10*lane +: 10];
   endfunction

   function automatic logic [LANES*10-1:0] pack_lane_y(input logic [LANES*10-1:0] ys,
                                                       input int unsigned         lane,
                                                       input logic [9:0]          y);
      logic [LANES*10-1:0] r;
      r = ys;
      r[10*lane +: 10] = y;
      return r;
   endfunction

endpackage

// File: rtl/tile_judge_if.sv
// Bundle between the game-logic side (keyboard, movers, HUD) and the hit judge.
// master drives keycode/spawn/positions, slave is the judge.
interface tile_judge_if #(
   parameter int unsigned LANES = tile_pkg::LANES
);

   logic [7:0]          keycode;
   logic [LANES-1:0]    note_spawn;
   logic [LANES*10-1:0] tile_y;

   logic [LANES-1:0]    kill;
   logic [3:0]          speed;
   logic [15:0]         score;
   logic [1:0]          lives;
   logic                game_over;
   logic                hit_pulse;
   logic                miss_pulse;

   modport master (
      output keycode, note_spawn, tile_y,
      input  kill, speed, score, lives, game_over, hit_pulse, miss_pulse
   );

   modport slave (
      input  keycode, note_spawn, tile_y,
      output kill, speed, score, lives, game_over, hit_pulse, miss_pulse
   );

endinterface

// File: rtl/tile_judge_key_edge.sv
// Keyboard edge detect: a lane press is reported only on the frame the keycode
// changes to that lane's code, so a held key yields exactly one press.
module key_edge #(
   parameter int unsigned LANES = tile_pkg::LANES
) (
   input  logic             frame_clk,
   input  logic             Reset_n,
   input  logic [7:0]       keycode,
   output logic [LANES-1:0] press
);
   import tile_pkg::*;

   logic [7:0] prev_q;

   // Remember last frame's keycode
   always_ff @(posedge frame_clk) begin
      if (!Reset_n) begin
         prev_q <= 8'h00;
      end else begin
         prev_q <= keycode;
      end
   end

   // One-hot lane decode, gated by a change in keycode; code 0 is "no key"
   always_comb begin
      press = '0;
      if ((keycode != prev_q) && (keycode != 8'h00)) begin
         for (int unsigned i = 0; i < LANES; i++) begin
            if (keycode == lane_key(i)) begin
               press[i] = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/tile_judge.sv
// Hit-judgement and game-state stage. Judges each lane's tile against the hit
// window once per frame, issues kill pulses back to the movers, and keeps
// score, lives and fall speed for the HUD. All outputs are registered.
module tile_judge #(
   parameter int unsigned LANES     = tile_pkg::LANES,
   parameter int unsigned TILE_SIZE = 75,
   parameter int unsigned HIT_TOP   = 330,
   parameter int unsigned HIT_BOT   = 479,
   parameter int unsigned LIVES     = 3,
   parameter int unsigned STEP_HITS = 8
) (
   input logic         frame_clk,
   input logic         Reset_n,
   tile_judge_if.slave bus
);
   import tile_pkg::*;

   localparam int unsigned CntW  = $clog2(STEP_HITS + 1);
   localparam int unsigned LossW = $clog2(LANES + 1);

   game_state_t         state_q, state_d;
   logic [LANES-1:0]    armed_q, armed_d;
   logic [LANES-1:0]    kill_q, kill_d;
   logic [3:0]          speed_q, speed_d;
   logic [15:0]         score_q, score_d;
   logic [1:0]          lives_q, lives_d;
   logic                hit_q, hit_d;
   logic                miss_q, miss_d;
   logic [CntW-1:0]     hit_cnt_q, hit_cnt_d;

   logic [LANES-1:0]    press;
   logic [LANES-1:0]    in_window;
   logic [LANES-1:0]    past_bottom;
   logic [LANES-1:0]    lane_hit;
   logic [LANES-1:0]    lane_wrong;
   logic [LANES-1:0]    lane_miss;
   logic [LossW-1:0]    loss_cnt;

   key_edge #(
      .LANES (LANES)
   ) u_key_edge (
      .frame_clk (frame_clk),
      .Reset_n   (Reset_n),
      .keycode   (bus.keycode),
      .press     (press)
   );

   // Per-lane classification. Bottom edge is formed at 11 bits so Y near the
   // top of the 10-bit range cannot wrap back into the window.
   for (genvar g = 0; g < LANES; g++) begin : g_lane
      logic [10:0] bottom;
      assign bottom         = 11'(bus.tile_y[10*g +: 10]) + 11'(TILE_SIZE);
      assign in_window[g]   = bottom >= 11'(HIT_TOP);
      assign past_bottom[g] = bottom >= 11'(HIT_BOT);
      // A press at or past the bottom still counts as a hit
      assign lane_hit[g]    = press[g] & armed_q[g] & in_window[g];
      assign lane_wrong[g]  = press[g] & ~(armed_q[g] & in_window[g]);
      assign lane_miss[g]   = ~press[g] & armed_q[g] & past_bottom[g];
   end

   // Count life losses this frame: one wrong press at most, several misses possible
   always_comb begin
      loss_cnt = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         loss_cnt = loss_cnt + LossW'(lane_wrong[i] | lane_miss[i]);
      end
   end

   // Game FSM next state plus all registered-output next values
   always_comb begin
      state_d   = state_q;
      armed_d   = armed_q;
      kill_d    = '0;
      speed_d   = speed_q;
      score_d   = score_q;
      lives_d   = lives_q;
      hit_d     = 1'b0;
      miss_d    = 1'b0;
      hit_cnt_d = hit_cnt_q;

      unique case (state_q)
         PLAY: begin
            // A spawn on the same lane re-arms it and suppresses the kill
            armed_d = (armed_q & ~(lane_hit | lane_miss)) | bus.note_spawn;
            kill_d  = (lane_hit | lane_miss) & ~bus.note_spawn;
            hit_d   = |lane_hit;
            miss_d  = (loss_cnt != '0);

            if (hit_d) begin
               if (score_q != 16'hFFFF) begin
                  score_d = score_q + 16'd1;
               end
               if (hit_cnt_q == CntW'(STEP_HITS - 1)) begin
                  hit_cnt_d = '0;
                  if (speed_q != 4'hF) begin
                     speed_d = speed_q + 4'd1;
                  end
               end else begin
                  hit_cnt_d = hit_cnt_q + CntW'(1);
               end
            end

            if (32'(loss_cnt) >= 32'(lives_q)) begin
               lives_d = 2'd0;
            end else begin
               lives_d = lives_q - 2'(loss_cnt);
            end

            if (lives_d == 2'd0) begin
               state_d = OVER;
            end
         end
         OVER: begin
            // Absorbing: everything holds, pulses stay low
         end
         default: begin
            state_d = PLAY;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge frame_clk) begin
      if (!Reset_n) begin
         state_q   <= PLAY;
         armed_q   <= '0;
         kill_q    <= '0;
         speed_q   <= 4'd0;
         score_q   <= 16'd0;
         lives_q   <= 2'(LIVES);
         hit_q     <= 1'b0;
         miss_q    <= 1'b0;
         hit_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         armed_q   <= armed_d;
         kill_q    <= kill_d;
         speed_q   <= speed_d;
         score_q   <= score_d;
         lives_q   <= lives_d;
         hit_q     <= hit_d;
         miss_q    <= miss_d;
         hit_cnt_q <= hit_cnt_d;
      end
   end

   assign bus.kill       = kill_q;
   assign bus.speed      = speed_q;
   assign bus.score      = score_q;
   assign bus.lives      = lives_q;
   assign bus.game_over  = (state_q == OVER);
   assign bus.hit_pulse  = hit_q;
   assign bus.miss_pulse = miss_q;

endmodule

// File: tb/tb_tile_judge.sv
// Bench for tile_judge: directed scenarios followed by randomized play, each
// frame checked against a behavioural model of the game rules.
module tb_tile_judge;
   import tile_pkg::*;

   localparam int NL = 4;

   logic frame_clk = 1'b0;
   logic Reset_n   = 1'b0;

   tile_judge_if #(.LANES(NL)) bus ();

   tile_judge #(
      .LANES     (NL),
      .TILE_SIZE (75),
      .HIT_TOP   (330),
      .HIT_BOT   (479),
      .LIVES     (3),
      .STEP_HITS (8)
   ) dut (
      .frame_clk (frame_clk),
      .Reset_n   (Reset_n),
      .bus       (bus)
   );

   always #5 frame_clk = ~frame_clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model state: rules expressed with plain integers
   byte unsigned codes [NL] = '{8'h04, 8'h16, 8'h07, 8'h09};
   logic [7:0]   m_prev;
   bit           m_armed [NL];
   int           m_hits;
   int           m_lives;
   bit           m_over;
   logic [3:0]   e_kill;
   bit           e_hit;
   bit           e_miss;
   logic [7:0]   last_kc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_prev  = 8'h00;
      for (int i = 0; i < NL; i++) m_armed[i] = 1'b0;
      m_hits  = 0;
      m_lives = 3;
      m_over  = 1'b0;
      e_kill  = '0;
      e_hit   = 1'b0;
      e_miss  = 1'b0;
   endtask

   task automatic model_step(input logic [7:0] kc, input logic [3:0] sp, input int ys [NL]);
      int lane;
      int loss;
      int bottom;
      lane = -1;
      loss = 0;
      if (kc != m_prev) begin
         for (int j = 0; j < NL; j++) if (kc == codes[j]) lane = j;
      end
      m_prev = kc;
      e_kill = '0;
      e_hit  = 1'b0;
      e_miss = 1'b0;
      if (m_over) return;
      for (int i = 0; i < NL; i++) begin
         bottom = ys[i] + 75;
         if (lane == i) begin
            if (m_armed[i] && bottom >= 330) begin
               e_kill[i]  = 1'b1;
               m_armed[i] = 1'b0;
               m_hits++;
               e_hit = 1'b1;
            end else begin
               loss++;
            end
         end else if (m_armed[i] && bottom >= 479) begin
            e_kill[i]  = 1'b1;
            m_armed[i] = 1'b0;
            loss++;
         end
         if (sp[i]) begin
            m_armed[i] = 1'b1;
            e_kill[i]  = 1'b0;
         end
      end
      m_lives = (loss >= m_lives) ? 0 : m_lives - loss;
      e_miss  = (loss > 0);
      if (m_lives == 0) m_over = 1'b1;
   endtask

   task automatic check_all(input string tag);
      int exp_score;
      int exp_speed;
      exp_score = (m_hits > 65535) ? 65535 : m_hits;
      exp_speed = (m_hits / 8 > 15) ? 15 : m_hits / 8;
      chk({tag, ".kill"},       32'(bus.kill),       32'(e_kill));
      chk({tag, ".score"},      32'(bus.score),      32'(exp_score));
      chk({tag, ".lives"},      32'(bus.lives),      32'(m_lives));
      chk({tag, ".speed"},      32'(bus.speed),      32'(exp_speed));
      chk({tag, ".game_over"},  32'(bus.game_over),  32'(m_over));
      chk({tag, ".hit_pulse"},  32'(bus.hit_pulse),  32'(e_hit));
      chk({tag, ".miss_pulse"}, 32'(bus.miss_pulse), 32'(e_miss));
   endtask

   task automatic frame(input string tag, input logic [7:0] kc, input logic [3:0] sp,
                        input int y0, input int y1, input int y2, input int y3);
      int                  ys [NL];
      logic [NL*10-1:0]    py;
      ys = '{y0, y1, y2, y3};
      py = '0;
      for (int i = 0; i < NL; i++) py = pack_lane_y(py, i, 10'(ys[i]));
      bus.keycode    = kc;
      bus.note_spawn = sp;
      bus.tile_y     = py;
      last_kc        = kc;
      model_step(kc, sp, ys);
      @(posedge frame_clk);
      #1;
      check_all(tag);
   endtask

   task automatic do_reset(input string tag);
      Reset_n        = 1'b0;
      bus.keycode    = 8'h00;
      bus.note_spawn = '0;
      bus.tile_y     = '0;
      last_kc        = 8'h00;
      @(posedge frame_clk);
      #1;
      model_reset();
      check_all(tag);
      Reset_n = 1'b1;
   endtask

   initial begin
      int          r;
      logic [7:0]  kc;
      logic [3:0]  sp;
      int          ry [NL];

      bus.keycode    = 8'h00;
      bus.note_spawn = '0;
      bus.tile_y     = '0;
      last_kc        = 8'h00;
      model_reset();
      @(posedge frame_clk);
      #1;
      do_reset("reset");
      chk("reset.lives_const", 32'(bus.lives), 32'd3);

      // Hit on lane 0 in the window
      frame("spawn0", 8'h00, 4'b0001, 0, 0, 0, 0);
      frame("hit0", 8'h04, 4'b0000, 260, 0, 0, 0);
      chk("hit0.kill_const", 32'(bus.kill), 32'b0001);
      chk("hit0.score_const", 32'(bus.score), 32'd1);
      chk("hit0.pulse_const", 32'(bus.hit_pulse), 32'd1);
      frame("hit0_after", 8'h04, 4'b0000, 260, 0, 0, 0);
      chk("hit0.kill_one_frame", 32'(bus.kill), 32'd0);

      // Wrong press above the window, then the tile falls through
      frame("spawn1", 8'h00, 4'b0010, 0, 200, 0, 0);
      frame("wrong1", 8'h16, 4'b0000, 0, 200, 0, 0);
      chk("wrong1.lives_const", 32'(bus.lives), 32'd2);
      chk("wrong1.kill_const", 32'(bus.kill), 32'd0);
      frame("miss1", 8'h00, 4'b0000, 0, 404, 0, 0);
      chk("miss1.kill_const", 32'(bus.kill), 32'b0010);
      chk("miss1.lives_const", 32'(bus.lives), 32'd1);

      // Double miss, then game over and ignored input
      do_reset("reset2");
      frame("spawn23", 8'h00, 4'b1100, 0, 0, 0, 0);
      frame("miss23", 8'h00, 4'b0000, 0, 0, 404, 404);
      chk("miss23.kill_const", 32'(bus.kill), 32'b1100);
      chk("miss23.lives_const", 32'(bus.lives), 32'd1);
      frame("spawn0b", 8'h00, 4'b0001, 0, 0, 0, 0);
      frame("miss0_over", 8'h00, 4'b0000, 404, 0, 0, 0);
      chk("over.go_const", 32'(bus.game_over), 32'd1);
      chk("over.lives_const", 32'(bus.lives), 32'd0);
      frame("over_press", 8'h04, 4'b1111, 260, 260, 260, 260);
      frame("over_fall", 8'h00, 4'b0000, 404, 404, 404, 404);
      chk("over.kill_const", 32'(bus.kill), 32'd0);

      // Reset from OVER
      do_reset("reset_over");
      chk("reset_over.go_const", 32'(bus.game_over), 32'd0);

      // Held key gives a single hit
      frame("spawn_hold", 8'h00, 4'b0001, 260, 0, 0, 0);
      for (int k = 0; k < 10; k++) frame("hold", 8'h04, 4'b0000, 260, 0, 0, 0);
      chk("hold.score_const", 32'(bus.score), 32'd1);

      // Spawn and hit in the same frame keeps lane 0 armed
      frame("release", 8'h00, 4'b0000, 0, 0, 0, 0);
      frame("spawn_sh", 8'h00, 4'b0001, 0, 0, 0, 0);
      frame("spawn_hit", 8'h04, 4'b0001, 260, 0, 0, 0);
      chk("spawn_hit.kill_const", 32'(bus.kill), 32'd0);
      chk("spawn_hit.score_const", 32'(bus.score), 32'd2);
      frame("still_armed", 8'h00, 4'b0000, 404, 0, 0, 0);
      chk("still_armed.kill_const", 32'(bus.kill), 32'b0001);

      // Speed ramp and saturation
      do_reset("reset_speed");
      for (int h = 1; h <= 136; h++) begin
         frame("sp_spawn", 8'h00, 4'b0001, 260, 0, 0, 0);
         frame("sp_hit", 8'h04, 4'b0000, 260, 0, 0, 0);
         if (h == 8)   chk("speed_after_8", 32'(bus.speed), 32'd1);
         if (h == 128) chk("speed_after_128", 32'(bus.speed), 32'd15);
         if (h == 136) chk("speed_after_136", 32'(bus.speed), 32'd15);
      end

      // Randomized play
      for (int blk = 0; blk < 8; blk++) begin
         do_reset("reset_rand");
         for (int f = 0; f < 60; f++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 1)      kc = last_kc;
            else if (r <= 3) kc = 8'h00;
            else if (r <= 7) kc = codes[r - 4];
            else if (r == 8) kc = 8'($urandom);
            else             kc = codes[$urandom_range(0, NL - 1)];
            for (int i = 0; i < NL; i++) begin
               sp[i] = ($urandom_range(0, 3) == 0);
               ry[i] = int'($urandom_range(0, 480));
            end
            frame("rand", kc, sp, ry[0], ry[1], ry[2], ry[3]);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
